// File: rtl/fp16_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fp16_dot_sequencer
// Purpose  : Feeds fp16 operand pairs into an external fp16*fp16+fp32 MAC
//            core and closes the accumulation loop to form fp32 dot products.
// Revision : 1.0  initial release
// ============================================================================
module fp16_dot_sequencer #(
   parameter int MAC_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ivalid,
   output logic             oready,
   input  logic [15:0]      datainA,
   input  logic [15:0]      datainB,
   input  logic             ilast,
   output logic             ovalid,
   input  logic             iready,
   output logic [31:0]      dataout,
   output logic [CNT_W-1:0] count,
   output logic [15:0]      mac_a,
   output logic [15:0]      mac_b,
   output logic [31:0]      mac_c,
   input  logic [31:0]      mac_q
);

   localparam int              WC_W        = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
   localparam logic [WC_W-1:0] c_WCNT_LOAD = WC_W'(MAC_LAT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        acc_q, acc_d;
   logic [CNT_W-1:0]   elem_cnt_q, elem_cnt_d;
   logic [WC_W-1:0]    wcnt_q, wcnt_d;
   logic               last_q, last_d;
   logic [31:0]        dataout_q, dataout_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [15:0]        mac_a_q, mac_a_d;
   logic [15:0]        mac_b_q, mac_b_d;
   logic [31:0]        mac_c_q, mac_c_d;
   logic               w_accept;

   assign oready   = (state_q == S_IDLE) && !reset;
   assign w_accept = ivalid && oready;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      elem_cnt_d = elem_cnt_q;
      wcnt_d     = wcnt_q;
      last_d     = last_q;
      dataout_d  = dataout_q;
      count_d    = count_q;
      mac_a_d    = mac_a_q;
      mac_b_d    = mac_b_q;
      mac_c_d    = mac_c_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               mac_a_d = datainA;
               mac_b_d = datainB;
               mac_c_d = acc_q;
               last_d  = ilast;
               if (!(&elem_cnt_q)) begin
                  elem_cnt_d = elem_cnt_q + 1'b1;
               end
               wcnt_d  = c_WCNT_LOAD;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Capture one cycle after the core's minimum latency; inputs are held stable meanwhile.
            if (wcnt_q == '0) begin
               acc_d = mac_q;
               if (last_q) begin
                  dataout_d  = mac_q;
                  count_d    = elem_cnt_q;
                  acc_d      = 32'h0000_0000;
                  elem_cnt_d = '0;
                  state_d    = S_DONE;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end
         S_DONE: begin
            if (iready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         elem_cnt_q <= '0;
         wcnt_q     <= '0;
         last_q     <= 1'b0;
         dataout_q  <= '0;
         count_q    <= '0;
         mac_a_q    <= '0;
         mac_b_q    <= '0;
         mac_c_q    <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         elem_cnt_q <= elem_cnt_d;
         wcnt_q     <= wcnt_d;
         last_q     <= last_d;
         dataout_q  <= dataout_d;
         count_q    <= count_d;
         mac_a_q    <= mac_a_d;
         mac_b_q    <= mac_b_d;
         mac_c_q    <= mac_c_d;
      end
   end

   assign ovalid  = (state_q == S_DONE);
   assign dataout = dataout_q;
   assign count   = count_q;
   assign mac_a   = mac_a_q;
   assign mac_b   = mac_b_q;
   assign mac_c   = mac_c_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_dot_sequencer
// Purpose  : Self-checking bench with a behavioural fixed-latency MAC model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp16_dot_sequencer;

   localparam int MAC_LAT = 4;
   localparam int CNT_W   = 16;
   localparam int LAT2    = 2;
   localparam int CNT2_W  = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic             reset, ivalid, ilast, iready;
   logic [15:0]      datainA, datainB;
   logic             oready, ovalid;
   logic [31:0]      dataout;
   logic [CNT_W-1:0] count;
   logic [15:0]      mac_a, mac_b;
   logic [31:0]      mac_c, mac_q;

   logic              ivalid2, ilast2, iready2;
   logic [15:0]       datainA2, datainB2;
   logic              oready2, ovalid2;
   logic [31:0]       dataout2;
   logic [CNT2_W-1:0] count2;
   logic [15:0]       mac2_a, mac2_b;
   logic [31:0]       mac2_c, mac2_q;

   fp16_dot_sequencer #(.MAC_LAT(MAC_LAT), .CNT_W(CNT_W)) u_dut (
      .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
      .datainA(datainA), .datainB(datainB), .ilast(ilast), .ovalid(ovalid),
      .iready(iready), .dataout(dataout), .count(count), .mac_a(mac_a),
      .mac_b(mac_b), .mac_c(mac_c), .mac_q(mac_q)
   );

   fp16_dot_sequencer #(.MAC_LAT(LAT2), .CNT_W(CNT2_W)) u_dut2 (
      .clock(clock), .reset(reset), .ivalid(ivalid2), .oready(oready2),
      .datainA(datainA2), .datainB(datainB2), .ilast(ilast2), .ovalid(ovalid2),
      .iready(iready2), .dataout(dataout2), .count(count2), .mac_a(mac2_a),
      .mac_b(mac2_b), .mac_c(mac2_c), .mac_q(mac2_q)
   );

   // ---------------- floating-point reference helpers ----------------
   function automatic real pow2(input int n);
      real r;
      r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp16_to_real(input logic [15:0] h);
      real v;
      if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
      else v = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
      return h[15] ? -v : v;
   endfunction

   function automatic real fp32_to_real(input logic [31:0] f);
      real v;
      if (f[30:23] == 8'd0) v = real'(f[22:0]) * pow2(-149);
      else v = real'(8388608 + int'(f[22:0])) * pow2(int'(f[30:23]) - 150);
      return f[31] ? -v : v;
   endfunction

   function automatic logic [31:0] real_to_fp32(input real x);
      logic        s;
      int          e;
      real         f;
      int unsigned m;
      if (x == 0.0) return 32'h0;
      s = (x < 0.0);
      f = s ? -x : x;
      e = 127;
      while (f >= 2.0) begin f = f / 2.0; e++; end
      while (f < 1.0 && e > 1) begin f = f * 2.0; e--; end
      m = unsigned'($rtoi((f - 1.0) * 8388608.0 + 0.5));
      if (m >= 32'd8388608) begin m = 0; e++; end
      return {s, 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] mac_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [31:0] c);
      return real_to_fp32(fp16_to_real(a) * fp16_to_real(b) + fp32_to_real(c));
   endfunction

   // MAC core models: result of inputs present before edge n appears after edge n+LAT-1.
   logic [31:0] pipe1 [MAC_LAT];
   logic [31:0] pipe2 [LAT2];
   always @(posedge clock) begin
      pipe1[0] <= mac_f(mac_a, mac_b, mac_c);
      for (int i = 1; i < MAC_LAT; i++) pipe1[i] <= pipe1[i-1];
      pipe2[0] <= mac_f(mac2_a, mac2_b, mac2_c);
      for (int j = 1; j < LAT2; j++) pipe2[j] <= pipe2[j-1];
   end
   assign mac_q  = pipe1[MAC_LAT-1];
   assign mac2_q = pipe2[LAT2-1];

   // ---------------- checking infrastructure ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] q;
      logic [15:0] cnt;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        last;
      logic [31:0] exp_c;
      logic [31:0] exp_q;
      logic [15:0] exp_cnt;
   } elem_t;

   res_t sb[$];
   res_t mon_r;

   // Result monitor: a handshake completes at the next rising edge.
   always @(negedge clock) begin
      if (!reset && ovalid && iready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_result: actual=%h required=none", dataout);
         end else begin
            mon_r = sb.pop_front();
            check("dataout", dataout, mon_r.q);
            check("count", 32'(count), 32'(mon_r.cnt));
         end
      end
   end

   task automatic send_elem(input elem_t e);
      int   k;
      res_t r;
      k = 0;
      while (!oready && k < 200) begin @(negedge clock); k++; end
      if (!oready) begin
         n_chk++;
         n_err++;
         $display("FAIL oready_timeout: actual=0 required=1");
         return;
      end
      ivalid  = 1'b1;
      datainA = e.a;
      datainB = e.b;
      ilast   = e.last;
      if (e.last) begin
         r.q   = e.exp_q;
         r.cnt = e.exp_cnt;
         sb.push_back(r);
      end
      @(posedge clock); #1;
      check("mac_a", 32'(mac_a), 32'(e.a));
      check("mac_b", 32'(mac_b), 32'(e.b));
      check("mac_c", mac_c, e.exp_c);
      ivalid  = 1'b0;
      datainA = 16'hDEAD;
      datainB = 16'hBEEF;
      ilast   = ~e.last;
      k = 0;
      do begin @(negedge clock); k++; end while (!(oready || ovalid) && k < 50);
      check("busy_cycles", 32'(k), 32'(MAC_LAT + 2));
      if (e.last) begin
         check("ovalid_rise", 32'(ovalid), 32'd1);
         if (iready) begin
            @(negedge clock);
            check("ovalid_pulse", 32'(ovalid), 32'd0);
            check("oready_after_done", 32'(oready), 32'd1);
         end
      end
   endtask

   task automatic send2(input logic [15:0] a, input logic [15:0] b, input logic last,
                        input logic [31:0] exp_c);
      int k;
      k = 0;
      while (!oready2 && k < 100) begin @(negedge clock); k++; end
      ivalid2  = 1'b1;
      datainA2 = a;
      datainB2 = b;
      ilast2   = last;
      @(posedge clock); #1;
      check("u2_mac_c", mac2_c, exp_c);
      ivalid2 = 1'b0;
      k = 0;
      do begin @(negedge clock); k++; end while (!(oready2 || ovalid2) && k < 50);
      check("u2_busy_cycles", 32'(k), 32'(LAT2 + 2));
   endtask

   elem_t tbl [6];

   initial begin
      #200000;
      $display("FAIL watchdog: actual=running required=finished");
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] exp_a, exp_b;
      logic        was_ready;
      int          last_acc, acc_n;

      tbl[0] = '{16'h4000, 16'h4200, 1'b1, 32'h0,         32'h40C0_0000, 16'd1};
      tbl[1] = '{16'h3C00, 16'h3C00, 1'b0, 32'h0,         32'h0,         16'd0};
      tbl[2] = '{16'h4000, 16'h4000, 1'b0, 32'h3F80_0000, 32'h0,         16'd0};
      tbl[3] = '{16'h4200, 16'h4200, 1'b1, 32'h40A0_0000, 32'h4160_0000, 16'd3};
      tbl[4] = '{16'h4400, 16'h3C00, 1'b1, 32'h0,         32'h4080_0000, 16'd1};
      tbl[5] = '{16'h3C00, 16'h3C00, 1'b1, 32'h0,         32'h3F80_0000, 16'd1};

      reset = 1'b1; ivalid = 1'b0; ilast = 1'b0; iready = 1'b1;
      datainA = 16'h0; datainB = 16'h0;
      ivalid2 = 1'b0; ilast2 = 1'b0; iready2 = 1'b1;
      datainA2 = 16'h0; datainB2 = 16'h0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_oready", 32'(oready), 32'd0);
      check("rst_ovalid", 32'(ovalid), 32'd0);
      check("rst_dataout", dataout, 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_mac_c", mac_c, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("oready_after_rst", 32'(oready), 32'd1);

      // Single-element and three-element vectors.
      for (int i = 0; i < 4; i++) send_elem(tbl[i]);

      // Backpressure in DONE.
      iready = 1'b0;
      send_elem(tbl[4]);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("bp_ovalid", 32'(ovalid), 32'd1);
         check("bp_oready", 32'(oready), 32'd0);
         check("bp_dataout", dataout, 32'h4080_0000);
         check("bp_count", 32'(count), 32'd1);
      end
      @(posedge clock); #1;
      iready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("bp_release", 32'(ovalid), 32'd0);
      send_elem(tbl[5]);

      // Continuous ivalid with changing data: only accept-edge values reach the core.
      exp_a = 16'h3C00; exp_b = 16'h3C00;
      last_acc = 0; acc_n = 0;
      ivalid = 1'b1; ilast = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         datainA = 16'h3C00 | 16'($urandom_range(0, 255));
         datainB = 16'h3C00 | 16'($urandom_range(0, 255));
         was_ready = oready;
         if (was_ready) begin exp_a = datainA; exp_b = datainB; end
         @(posedge clock); #1;
         check("stream_mac_a", 32'(mac_a), 32'(exp_a));
         check("stream_mac_b", 32'(mac_b), 32'(exp_b));
         if (was_ready) begin
            if (acc_n > 0) check("stream_period", 32'(cyc - last_acc), 32'(MAC_LAT + 2));
            last_acc = cyc;
            acc_n++;
         end
         @(negedge clock);
      end
      ivalid = 1'b0;
      check("stream_accepts", 32'(acc_n >= 3), 32'd1);
      reset = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      reset = 1'b0;

      // Reset during WAIT of element 2.
      send_elem('{16'h3C00, 16'h3C00, 1'b0, 32'h0, 32'h0, 16'd0});
      ivalid = 1'b1; datainA = 16'h4000; datainB = 16'h4000; ilast = 1'b0;
      @(posedge clock); #1;
      check("rw_mac_c", mac_c, 32'h3F80_0000);
      ivalid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      check("rw_ovalid", 32'(ovalid), 32'd0);
      check("rw_oready", 32'(oready), 32'd0);
      check("rw_mac_a", 32'(mac_a), 32'd0);
      check("rw_mac_b", 32'(mac_b), 32'd0);
      check("rw_mac_c", mac_c, 32'h0);
      check("rw_dataout", dataout, 32'h0);
      check("rw_count", 32'(count), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rw_oready_back", 32'(oready), 32'd1);
      send_elem('{16'h3C00, 16'h4000, 1'b1, 32'h0, 32'h4000_0000, 16'd1});

      // Short-latency build, narrow counter saturating at 3.
      send2(16'h3C00, 16'h3C00, 1'b0, 32'h0);
      send2(16'h3C00, 16'h3C00, 1'b0, 32'h3F80_0000);
      send2(16'h3C00, 16'h3C00, 1'b0, 32'h4000_0000);
      send2(16'h3C00, 16'h3C00, 1'b1, 32'h4040_0000);
      check("u2_ovalid", 32'(ovalid2), 32'd1);
      check("u2_dataout", dataout2, 32'h4080_0000);
      check("u2_count_sat", 32'(count2), 32'd3);
      @(negedge clock);
      check("u2_ovalid_drop", 32'(ovalid2), 32'd0);

      repeat (3) @(negedge clock);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
